// File: rtl/ir_nec_pkg.sv
// NEC IR decoder shared types: FSM states, microsecond window bounds.
// Window bounds are inclusive and given in microseconds.
package ir_nec_pkg;

  localparam int IW = 14;

  typedef logic [IW-1:0] us_t;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    RPT_MARK
  } state_t;

  localparam us_t LEAD_MARK_MIN  = 14'd8000;
  localparam us_t LEAD_MARK_MAX  = 14'd10000;
  localparam us_t LEAD_SPACE_MIN = 14'd4000;
  localparam us_t LEAD_SPACE_MAX = 14'd5000;
  localparam us_t RPT_SPACE_MIN  = 14'd2000;
  localparam us_t RPT_SPACE_MAX  = 14'd2500;
  localparam us_t BIT_MARK_MIN   = 14'd400;
  localparam us_t BIT_MARK_MAX   = 14'd750;
  localparam us_t ZERO_SPACE_MIN = 14'd400;
  localparam us_t ZERO_SPACE_MAX = 14'd750;
  localparam us_t ONE_SPACE_MIN  = 14'd1400;
  localparam us_t ONE_SPACE_MAX  = 14'd1900;

  function automatic logic in_win(
    us_t v,
    us_t lo,
    us_t hi
  );
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/ir_us_timer.sv
// Microsecond interval timer: prescaler plus saturating 14-bit counter.
// clear restarts both the prescaler and the count.
module ir_us_timer
  import ir_nec_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int TIMEOUT_US = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output us_t  interval,
  output logic timeout
);

  localparam int DIV = CLK_HZ / 1_000_000;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PTOP = PW'(DIV - 1);

  logic [PW-1:0] pre;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre      <= '0;
      interval <= '0;
    end else if (clear) begin
      pre      <= '0;
      interval <= '0;
    end else if (pre == PTOP) begin
      pre <= '0;
      if (interval != '1)
        interval <= interval + 1'b1;
    end else begin
      pre <= pre + 1'b1;
    end
  end

  assign timeout = interval >= us_t'(TIMEOUT_US);

endmodule

// File: rtl/ir_nec_decoder.sv
// NEC IR frame decoder: leader/bit/repeat FSM over synchronizer edge ticks.
// Define IR_NEC_CHECK_EN to reject frames whose complement bytes mismatch.
module ir_nec_decoder
  import ir_nec_pkg::*;
#(
  parameter int CLK_HZ     = 12_000_000,
  parameter int TIMEOUT_US = 12000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fall_tick,
  input  logic       rise_tick,
  output logic       data_valid,
  output logic       repeat_valid,
  output logic       error,
  output logic       busy,
  output logic [7:0] address,
  output logic [7:0] command
);

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [30:0] shreg;
  logic        frame_seen;
  us_t         interval;
  logic        timeout;
  logic        clear;
  logic        any_edge;
  logic        both;
  logic        acc;
  logic        fault;
  logic        lead_sp;
  logic        rpt_sp;
  logic        mark_ok;
  logic        is_zero;
  logic        is_one;
  logic        cmp_ok;
  logic [31:0] sr_next;

  assign any_edge = fall_tick | rise_tick;
  assign both     = fall_tick & rise_tick;
  assign clear    = (state == IDLE) | any_edge;
  assign busy     = (state != IDLE);

  ir_us_timer #(
    .CLK_HZ     (CLK_HZ),
    .TIMEOUT_US (TIMEOUT_US)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .interval (interval),
    .timeout  (timeout)
  );

  assign lead_sp = in_win(interval, LEAD_SPACE_MIN, LEAD_SPACE_MAX);
  assign rpt_sp  = in_win(interval, RPT_SPACE_MIN, RPT_SPACE_MAX);
  assign mark_ok = in_win(interval, BIT_MARK_MIN, BIT_MARK_MAX);
  assign is_zero = in_win(interval, ZERO_SPACE_MIN, ZERO_SPACE_MAX);
  assign is_one  = in_win(interval, ONE_SPACE_MIN, ONE_SPACE_MAX);
  assign sr_next = {is_one, shreg};

`ifdef IR_NEC_CHECK_EN
  assign cmp_ok = (sr_next[15:8] == ~sr_next[7:0]) &&
                  (sr_next[31:24] == ~sr_next[23:16]);
`else
  assign cmp_ok = 1'b1;
`endif

  always_comb begin
    acc = 1'b1;
    unique case (state)
      IDLE:       acc = 1'b1;
      LEAD_MARK:  acc = rise_tick &&
                        in_win(interval, LEAD_MARK_MIN, LEAD_MARK_MAX);
      LEAD_SPACE: acc = fall_tick && (lead_sp || rpt_sp);
      BIT_MARK:   acc = rise_tick && mark_ok;
      BIT_SPACE:  acc = fall_tick && (is_zero || is_one);
      RPT_MARK:   acc = rise_tick && mark_ok && frame_seen;
      default:    acc = 1'b1;
    endcase
  end

  assign fault = (state != IDLE) && any_edge && !acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      frame_seen   <= 1'b0;
      data_valid   <= 1'b0;
      repeat_valid <= 1'b0;
      error        <= 1'b0;
      address      <= '0;
      command      <= '0;
    end else begin
      data_valid   <= 1'b0;
      repeat_valid <= 1'b0;
      error        <= 1'b0;
      if ((state != IDLE) && timeout) begin
        error      <= 1'b1;
        frame_seen <= 1'b0;
        state      <= IDLE;
      end else if (both) begin
        state <= IDLE;
      end else if (fault) begin
        error      <= 1'b1;
        frame_seen <= 1'b0;
        state      <= IDLE;
      end else begin
        unique case (state)
          IDLE:
            if (fall_tick) state <= LEAD_MARK;
          LEAD_MARK:
            if (rise_tick) state <= LEAD_SPACE;
          LEAD_SPACE:
            if (fall_tick) begin
              if (lead_sp) begin
                bit_cnt <= '0;
                state   <= BIT_MARK;
              end else begin
                state <= RPT_MARK;
              end
            end
          BIT_MARK:
            if (rise_tick) state <= BIT_SPACE;
          BIT_SPACE:
            if (fall_tick) begin
              shreg <= sr_next[31:1];
              if (bit_cnt == 5'd31) begin
                state <= IDLE;
                if (cmp_ok) begin
                  address    <= sr_next[7:0];
                  command    <= sr_next[23:16];
                  data_valid <= 1'b1;
                  frame_seen <= 1'b1;
                end else begin
                  error      <= 1'b1;
                  frame_seen <= 1'b0;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                state   <= BIT_MARK;
              end
            end
          RPT_MARK:
            if (rise_tick) begin
              repeat_valid <= 1'b1;
              state        <= IDLE;
            end
          default:
            state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ir_nec_decoder.sv
// Scoreboard bench for ir_nec_decoder at 1 MHz (one clock per microsecond).
// Stimulus pushes expected pulses; a negedge monitor pops and compares.
module tb_ir_nec_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       fall_tick = 1'b0;
  logic       rise_tick = 1'b0;
  logic       data_valid;
  logic       repeat_valid;
  logic       error;
  logic       busy;
  logic [7:0] address;
  logic [7:0] command;

  typedef struct packed {
    logic [2:0] kind;
    logic [7:0] addr;
    logic [7:0] cmd;
  } exp_t;

  localparam logic [2:0] K_DV  = 3'b100;
  localparam logic [2:0] K_RPT = 3'b010;
  localparam logic [2:0] K_ERR = 3'b001;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  ir_nec_decoder #(
    .CLK_HZ     (1_000_000),
    .TIMEOUT_US (12000)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .fall_tick    (fall_tick),
    .rise_tick    (rise_tick),
    .data_valid   (data_valid),
    .repeat_valid (repeat_valid),
    .error        (error),
    .busy         (busy),
    .address      (address),
    .command      (command)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic push(logic [2:0] k, logic [7:0] a, logic [7:0] c);
    exp_t e;
    e.kind = k;
    e.addr = a;
    e.cmd  = c;
    q.push_back(e);
  endtask

  // Monitor: any output pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (data_valid | repeat_valid | error) begin
      if (q.size() == 0) begin
        chk("unexpected_pulse", {29'd0, data_valid, repeat_valid, error}, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("pulse_kind", {29'd0, data_valid, repeat_valid, error},
            {29'd0, e.kind});
        if (e.kind == K_DV) begin
          chk("dv_address", {24'd0, address}, {24'd0, e.addr});
          chk("dv_command", {24'd0, command}, {24'd0, e.cmd});
        end
      end
    end
  end

  task automatic pulse(bit is_fall, int us);
    repeat (us - 1) @(negedge clk);
    if (is_fall) fall_tick = 1'b1;
    else rise_tick = 1'b1;
    @(negedge clk);
    fall_tick = 1'b0;
    rise_tick = 1'b0;
  endtask

  task automatic send_bits(logic [31:0] w, int n);
    pulse(1'b1, 20);
    pulse(1'b0, 9000);
    pulse(1'b1, 4500);
    for (int i = 0; i < n; i++) begin
      pulse(1'b0, 560);
      pulse(1'b1, w[i] ? 1690 : 560);
    end
  endtask

  task automatic send_frame(logic [31:0] w);
    send_bits(w, 32);
    pulse(1'b0, 560);
  endtask

  task automatic send_repeat();
    pulse(1'b1, 20);
    pulse(1'b0, 9000);
    pulse(1'b1, 2250);
    pulse(1'b0, 560);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (5) @(negedge clk);
    chk("rst_data_valid", {31'd0, data_valid}, 32'd0);
    chk("rst_repeat_valid", {31'd0, repeat_valid}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_address", {24'd0, address}, 32'd0);
    chk("rst_command", {24'd0, command}, 32'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Repeat code before any frame is an error.
    push(K_ERR, 8'h00, 8'h00);
    send_repeat();
    repeat (3) @(negedge clk);
    chk("rpt_no_frame_busy", {31'd0, busy}, 32'd0);

    // Legal frame: 00 FF 45 BA.
    push(K_DV, 8'h00, 8'h45);
    send_frame(32'hBA45FF00);
    repeat (50) @(negedge clk);
    chk("after_frame_busy", {31'd0, busy}, 32'd0);

    // Repeat code after a frame; outputs held.
    push(K_RPT, 8'h00, 8'h00);
    send_repeat();
    repeat (3) @(negedge clk);
    chk("rpt_address_held", {24'd0, address}, 32'h00);
    chk("rpt_command_held", {24'd0, command}, 32'h45);

    // Corrupted inverted command byte.
`ifdef IR_NEC_CHECK_EN
    push(K_ERR, 8'h00, 8'h00);
`else
    push(K_DV, 8'h00, 8'h45);
`endif
    send_frame(32'hBB45FF00);
    repeat (50) @(negedge clk);
    chk("bad_frame_command", {24'd0, command}, 32'h45);

    // Leader then line stays high until timeout.
    push(K_ERR, 8'h00, 8'h00);
    pulse(1'b1, 20);
    pulse(1'b0, 9000);
    repeat (100) @(negedge clk);
    chk("timeout_busy_before", {31'd0, busy}, 32'd1);
    n = 100;
    while (!error && n < 13000) begin
      @(negedge clk);
      n++;
    end
    chk("timeout_seen", {31'd0, error}, 32'd1);
    chk("timeout_window", {31'd0, (n >= 11995 && n <= 12005)}, 32'd1);
    chk("timeout_busy_after", {31'd0, busy}, 32'd0);

    // Reset mid-frame: no pulses, reset values restored.
    send_bits(32'hED12FF00, 16);
    chk("midframe_busy", {31'd0, busy}, 32'd1);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_command", {24'd0, command}, 32'd0);
    chk("midrst_dv", {31'd0, data_valid}, 32'd0);
    rst = 1'b1;
    repeat (100) @(negedge clk);

    // Fresh frame: 00 FF 12 ED.
    push(K_DV, 8'h00, 8'h12);
    send_frame(32'hED12FF00);
    repeat (2000) @(negedge clk);
    chk("scoreboard_drained", q.size(), 32'd0);
    chk("final_busy", {31'd0, busy}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
